// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed hex display scanner.
package display_pkg;

  localparam int HEX_W      = 4;
  localparam int MAX_DIGITS = 8;

  // All anodes off (active-low); callers slice down to their digit count.
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Digit index width, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler and digit index counter for the display scanner.
// Exposes both current and next-cycle slot state so the parent can keep
// its anode register aligned with the counters.
module scan_tick_gen
  import display_pkg::*;
#(
  parameter  int DIGITS   = 4,
  parameter  int PRESCALE = 50000,
  parameter  int GUARD    = 2,
  localparam int AW       = addr_w(DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] idx_o,
  output logic [AW-1:0] idx_nxt_o,
  output logic          in_guard_nxt_o,
  output logic          frame_boundary_o
);

  localparam int PW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] GUARD_V  = PW'(GUARD);
  localparam logic [AW-1:0] IDX_LAST = AW'(DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wrap;

  // Next-state: prescaler wraps every slot, index advances on each wrap.
  always_comb begin
    wrap    = (presc_q == PRE_LAST);
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign idx_o            = idx_q;
  assign idx_nxt_o        = idx_d;
  assign in_guard_nxt_o   = (presc_d < GUARD_V);
  assign frame_boundary_o = wrap && (idx_q == IDX_LAST);

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scan controller feeding a hex-to-7-segment decoder.
// Host writes go to a shadow bank; the displayed (active) bank is only
// reloaded at a frame boundary, so a multi-digit update never tears.
module display_scanner
  import display_pkg::*;
#(
  parameter  int DIGITS   = 4,
  parameter  int PRESCALE = 50000,
  parameter  int GUARD    = 2,
  localparam int AW       = addr_w(DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [HEX_W-1:0]  wr_data,
  input  logic              commit,
  input  logic [DIGITS-1:0] en_mask,
  output logic [HEX_W-1:0]  digit_out,
  output logic [DIGITS-1:0] anode_n,
  output logic              pending,
  output logic              frame_tick
);

  localparam logic [AW:0] DIGITS_V = (AW + 1)'(DIGITS);

  logic [HEX_W-1:0]  shadow_q [DIGITS];
  logic [HEX_W-1:0]  active_q [DIGITS];
  logic              pending_q;
  logic              tick_q;
  logic [DIGITS-1:0] anode_q, anode_d;

  logic [AW-1:0] idx, idx_nxt;
  logic          in_guard_nxt;
  logic          frame_boundary;
  logic          wr_ok;
  logic          do_copy;

  scan_tick_gen #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) u_tick (
    .clk              (clk),
    .rst_n            (rst_n),
    .idx_o            (idx),
    .idx_nxt_o        (idx_nxt),
    .in_guard_nxt_o   (in_guard_nxt),
    .frame_boundary_o (frame_boundary)
  );

  // Out-of-range addresses (non power-of-two DIGITS) are dropped.
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DIGITS_V);
  // A commit arriving in the boundary cycle itself is honoured immediately.
  assign do_copy = frame_boundary && (pending_q || commit);

  // Host writes land in the shadow bank only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) shadow_q[i] <= '0;
    end else if (wr_ok) begin
      shadow_q[wr_addr] <= wr_data;
    end
  end

  // Active bank reloads from the pre-write shadow contents at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) active_q[i] <= '0;
    end else if (do_copy) begin
      for (int i = 0; i < DIGITS; i++) active_q[i] <= shadow_q[i];
    end
  end

  // Anode pattern for the upcoming cycle: dark during guard, else one digit.
  always_comb begin
    anode_d = ANODE_OFF[DIGITS-1:0];
    if (!in_guard_nxt) begin
      anode_d[idx_nxt] = ~en_mask[idx_nxt];
    end
  end

  // Commit tracking, frame pulse and registered anode drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      anode_q   <= ANODE_OFF[DIGITS-1:0];
    end else begin
      if (do_copy)     pending_q <= 1'b0;
      else if (commit) pending_q <= 1'b1;
      tick_q  <= frame_boundary;
      anode_q <= anode_d;
    end
  end

  assign digit_out  = active_q[idx];
  assign anode_n    = anode_q;
  assign pending    = pending_q;
  assign frame_tick = tick_q;

endmodule
